// File: rtl/jt51_acc_mix_if.sv
// Operator-sample input and stereo-output bundle for the jt51 output accumulator.
interface jt51_acc_mix_if #(
  parameter int unsigned OUT_W = 16
);
  logic                    cen;
  logic                    zero;
  logic signed [13:0]      op_in;
  logic        [2:0]       con;
  logic        [1:0]       rl;
  logic signed [OUT_W-1:0] left;
  logic signed [OUT_W-1:0] right;
  logic                    sample;

  modport master (
    output cen, zero, op_in, con, rl,
    input  left, right, sample
  );

  modport slave (
    input  cen, zero, op_in, con, rl,
    output left, right, sample
  );
endinterface

// File: rtl/jt51_acc_mix.sv
// Output accumulator: picks carrier operators per channel, sums them in an 8-deep
// circular buffer, routes channel sums to L/R and emits saturated stereo once per frame.
module jt51_acc_mix #(
  parameter int unsigned OUT_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  jt51_acc_mix_if.slave   bus
);

  localparam logic signed [18:0] SatMax = 19'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [18:0] SatMin = -SatMax - 19'sd1;

  logic        [4:0]       cnt_q, cnt_d;
  logic signed [15:0]      buf_q [8];
  logic signed [18:0]      acc_l_q, acc_l_d;
  logic signed [18:0]      acc_r_q, acc_r_d;
  logic signed [OUT_W-1:0] left_q, left_d;
  logic signed [OUT_W-1:0] right_q, right_d;
  logic                    sample_q, sample_d;

  logic        [4:0]       slot;
  logic        [1:0]       grp;
  logic                    is_car;
  logic signed [15:0]      v;
  logic signed [15:0]      cs;
  logic signed [15:0]      push;
  logic signed [18:0]      sum_l, sum_r;

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [18:0] x);
    if (x > SatMax) return SatMax[OUT_W-1:0];
    if (x < SatMin) return SatMin[OUT_W-1:0];
    return x[OUT_W-1:0];
  endfunction

  // Slot decode, carrier selection, channel-sum update and frame-end next state.
  always_comb begin
    slot = bus.zero ? 5'd0 : cnt_q;
    grp  = slot[4:3];
    cnt_d = bus.zero ? 5'd1 : cnt_q + 5'd1;

    unique case (grp)
      2'd0:    is_car = (bus.con == 3'd7);
      2'd1:    is_car = (bus.con >= 3'd5);
      2'd2:    is_car = (bus.con >= 3'd4);
      default: is_car = 1'b1;
    endcase

    v  = is_car ? {{2{bus.op_in[13]}}, bus.op_in} : 16'sd0;
    cs = buf_q[0] + v;

    unique case (grp)
      2'd0:    push = v;
      2'd1,
      2'd2:    push = cs;
      default: push = 16'sd0;
    endcase

    sum_l = acc_l_q;
    sum_r = acc_r_q;
    if (grp == 2'd3) begin
      if (bus.rl[0]) sum_l = acc_l_q + {{3{cs[15]}}, cs};
      if (bus.rl[1]) sum_r = acc_r_q + {{3{cs[15]}}, cs};
    end

    left_d   = left_q;
    right_d  = right_q;
    sample_d = 1'b0;
    acc_l_d  = sum_l;
    acc_r_d  = sum_r;
    if (slot == 5'd31) begin
      left_d   = sat(sum_l);
      right_d  = sat(sum_r);
      sample_d = 1'b1;
      acc_l_d  = 19'sd0;
      acc_r_d  = 19'sd0;
    end
  end

  // All state advances on cen; the buffer shifts every slot so an entry returns 8 slots later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 5'd0;
      acc_l_q  <= 19'sd0;
      acc_r_q  <= 19'sd0;
      left_q   <= '0;
      right_q  <= '0;
      sample_q <= 1'b0;
      for (int i = 0; i < 8; i++) buf_q[i] <= 16'sd0;
    end else if (bus.cen) begin
      cnt_q    <= cnt_d;
      acc_l_q  <= acc_l_d;
      acc_r_q  <= acc_r_d;
      left_q   <= left_d;
      right_q  <= right_d;
      sample_q <= sample_d;
      for (int i = 0; i < 7; i++) buf_q[i] <= buf_q[i+1];
      buf_q[7] <= push;
    end
  end

  assign bus.left   = left_q;
  assign bus.right  = right_q;
  assign bus.sample = sample_q;

endmodule

// File: tb/tb_jt51_acc_mix.sv
// Directed bench for jt51_acc_mix: whole frames with hand-computed stereo results.
module tb_jt51_acc_mix;

  logic clk;
  logic rst_n;
  jt51_acc_mix_if #(.OUT_W(16)) bus ();

  jt51_acc_mix #(.OUT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulse_cnt;
  int pulse_cyc;
  int zero_cyc;
  logic signed [13:0] op_tab [32];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic signed [13:0] val);
    for (int i = 0; i < 32; i++) op_tab[i] = val;
  endtask

  // Observe the strobe produced by the previously driven cen slot.
  task automatic note_sample();
    if (bus.cen && bus.sample) begin
      pulse_cnt++;
      pulse_cyc = cyc + 1;
    end
  endtask

  task automatic run_slots(input int first, input int count);
    for (int k = 0; k < count; k++) begin
      @(negedge clk);
      note_sample();
      bus.cen   = 1'b1;
      bus.zero  = ((first + k) == 0);
      bus.op_in = op_tab[first + k];
      cyc++;
      if (bus.zero) zero_cyc = cyc;
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    note_sample();
    bus.cen  = 1'b0;
    bus.zero = 1'b0;
  endtask

  task automatic frame(input logic [2:0] con, input logic [1:0] rl);
    bus.con   = con;
    bus.rl    = rl;
    pulse_cnt = 0;
    run_slots(0, 32);
    end_frame();
  endtask

  initial begin
    bus.cen   = 1'b0;
    bus.zero  = 1'b0;
    bus.op_in = '0;
    bus.con   = '0;
    bus.rl    = '0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_left", int'(bus.left), 0);
    check_eq("reset_right", int'(bus.right), 0);
    check_eq("reset_sample", int'(bus.sample), 0);
    rst_n = 1'b1;

    fill(14'sd100);
    frame(3'd7, 2'b11);
    check_eq("all_car_left", int'(bus.left), 3200);
    check_eq("all_car_right", int'(bus.right), 3200);
    check_eq("all_car_pulses", pulse_cnt, 1);
    check_eq("all_car_strobe_held", int'(bus.sample), 1);

    fill(14'sd1000);
    frame(3'd0, 2'b01);
    check_eq("con0_left", int'(bus.left), 8000);
    check_eq("con0_right", int'(bus.right), 0);
    check_eq("con0_pulses", pulse_cnt, 1);

    fill(14'sd0);
    op_tab[3]  = 14'sd5;
    op_tab[11] = 14'sd7;
    op_tab[19] = 14'sd11;
    op_tab[27] = 14'sd13;
    frame(3'd4, 2'b10);
    check_eq("con4_ch3_left", int'(bus.left), 0);
    check_eq("con4_ch3_right", int'(bus.right), 24);

    fill(14'sd8191);
    frame(3'd7, 2'b11);
    check_eq("sat_pos_left", int'(bus.left), 32767);
    check_eq("sat_pos_right", int'(bus.right), 32767);

    fill(-14'sd8192);
    frame(3'd7, 2'b11);
    check_eq("sat_neg_left", int'(bus.left), -32768);
    check_eq("sat_neg_right", int'(bus.right), -32768);

    // Reset mid-frame with nonzero accumulators (slots 24..27 already routed).
    fill(14'sd100);
    bus.con = 3'd7;
    bus.rl  = 2'b11;
    run_slots(0, 28);
    @(negedge clk);
    bus.cen = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_eq("midreset_left", int'(bus.left), 0);
    check_eq("midreset_right", int'(bus.right), 0);
    check_eq("midreset_sample", int'(bus.sample), 0);
    @(negedge clk);
    rst_n = 1'b1;
    fill(14'sd1000);
    frame(3'd0, 2'b01);
    check_eq("post_reset_left", int'(bus.left), 8000);
    check_eq("post_reset_right", int'(bus.right), 0);

    // Resync: zero arrives where slot 12 would have been.
    fill(14'sd100);
    bus.con   = 3'd7;
    bus.rl    = 2'b11;
    pulse_cnt = 0;
    run_slots(0, 12);
    check_eq("trunc_no_pulse", pulse_cnt, 0);
    run_slots(0, 32);
    end_frame();
    check_eq("resync_pulses", pulse_cnt, 1);
    check_eq("resync_delay", pulse_cyc - zero_cyc, 32);
    check_eq("resync_left", int'(bus.left), 3200);
    check_eq("resync_right", int'(bus.right), 3200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jt51_acc_mix.md
Name: jt51_acc_mix

Overview:
- Output accumulator directly downstream of the pipelined operator stage.
- Consumes one signed 14-bit operator sample per slot, 32 slots per frame (4 operator groups × 8 channels).
- Selects carrier operators from the channel's connection algorithm and sums them per channel in an 8-deep circular buffer.
- Routes each channel sum to left/right, accumulates over the frame, and emits saturated stereo samples once per frame with a strobe.

Parameters:
- OUT_W, 16: width of the left/right outputs; saturation bound is ±(2^(OUT_W-1)) range; legal values 14..19.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; all state advances only on clk edges with cen=1
- zero  in  1  frame marker; high with cen means the current op_in belongs to slot 0
- op_in  in  14  signed operator output for the current slot
- con  in  3  connection algorithm of the channel owning the current slot
- rl  in  2  output enables of that channel; rl[0]=left, rl[1]=right
- left  out  OUT_W  signed left sample, saturated
- right  out  OUT_W  signed right sample, saturated
- sample  out  1  frame-complete strobe

Behaviour:
- Reset: rst_n low clears slot counter, channel buffer, both accumulators, left, right and sample to 0; asynchronous, effective mid-frame; first frame after release restarts at slot 0.
- Slot counter s (5 bits):
  - On cen, s <= 1 if zero, else s+1, wrapping 31->0.
  - The slot being processed is 0 when zero=1, else s.
  - Group g = slot[4:3]: 0=M1, 1=M2, 2=C1, 3=C2. Channel = slot[2:0].
- Carrier selection (is_car): C2 is always a carrier; con 0-3: C2 only; con 4: C1,C2; con 5,6: M2,C1,C2; con 7: all four. Contribution v = is_car ? sign-extended op_in : 0.
- Channel buffer: 8 × 16-bit signed shift register, advances every cen, so a channel's entry returns after 8 slots.
  - g=0: push v (restarts the channel sum).
  - g=1,2: push head+v.
  - g=3: channel sum cs = head+v; push don't-care (0 is pushed).
- Width rules:
  - The 16-bit channel sum never overflows (4×14-bit range −32768..32764).
  - Accumulators are 19-bit signed; 8 × 16-bit sums cannot overflow them. No wrap anywhere.
- Routing, g=3 only: accL += rl[0] ? cs : 0; accR += rl[1] ? cs : 0.
- Frame end, on cen while processing slot 31:
  - left <= sat(accL+contribL), right <= sat(accR+contribR), where sat clamps to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - accL, accR <= 0.
  - sample <= 1.
- On every other cen, sample <= 0. sample is therefore high for exactly one cen period; it holds while cen is low.
- left/right hold between frames. Latency: slot-31 input to valid output is one cen-qualified edge.
- zero arriving early mid-frame: counter resyncs to slot 1; the partial frame is not output. Accumulators and buffer are not cleared by zero; stale partial sums contaminate at most one frame.
- zero coinciding with the natural wrap (s=0): identical to normal operation.
- cen low: no state change, inputs ignored.

Test Plan:
- Reset: rst_n low mid-frame with accL nonzero -> left=right=0, sample=0 immediately; next full frame is computed from slot 0 only.
- con=7, rl=2'b11, all 32 slots op_in=+100 -> each channel sum 400, left=right=3200, sample pulses once after slot 31.
- con=0, rl=2'b01, op_in=+1000 in every slot -> only C2 counts, left=8000, right=0.
- con=4, channel 3 only: M1=+5, M2=+7, C1=+11, C2=+13, rl=2'b10, all other slots 0 -> right=24, left=0.
- Saturation: con=7, rl=2'b11, op_in=+8191 all slots -> left=right=32767; op_in=−8192 -> −32768.
- Resync: pulse zero at slot 12 of a running frame -> no sample for the truncated frame; next sample exactly 32 cen cycles after the zero.
